// File: rtl/pipeline_ctrl_pkg.sv
// Purpose: shared types and constants for the pipeline hazard/stall controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

   localparam int TIMEOUT_CYC_DEF = 16;  // default MEM_WAIT budget before forced release
   localparam int CNT_W_DEF       = 16;  // default stall_count width
   localparam int WAIT_W          = 8;   // wide enough for TIMEOUT_CYC up to 255

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_TIMEOUT  = 2'd2
   } state_t;

   // Per-cycle pipeline control word, one bit per hold/flush/pulse output
   typedef struct packed {
      logic pc_hold;
      logic ifid_hold;
      logic idex_hold;
      logic exmem_hold;
      logic ifid_flush;
      logic idex_flush;
      logic memwb_flush;
      logic mem_timeout;
   } ctrl_t;

   // Load in EX writes a register the ID instruction reads; $zero never hazards
   function automatic logic load_use_hit(input logic       mem_read,
                                         input logic [4:0] ex_rt,
                                         input logic [4:0] id_rs,
                                         input logic [4:0] id_rt);
      return mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Purpose: bundles the hazard inputs and the hold/flush outputs of the pipeline controller.
// Latency: n/a (wiring only).
// Backpressure: n/a; "master" is the datapath side, "slave" is the controller.
interface pipeline_ctrl_if
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);
   logic [4:0]       ifid_rs;
   logic [4:0]       ifid_rt;
   logic             idex_mem_read;
   logic [4:0]       idex_rt;
   logic             ex_branch_taken;
   logic             id_jump;
   logic             mem_req;
   logic             mem_ready;

   logic             pc_hold;
   logic             ifid_hold;
   logic             idex_hold;
   logic             exmem_hold;
   logic             ifid_flush;
   logic             idex_flush;
   logic             memwb_flush;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output ifid_rs, ifid_rt, idex_mem_read, idex_rt, ex_branch_taken, id_jump,
             mem_req, mem_ready,
      input  pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush,
             memwb_flush, mem_timeout, stall_count
   );

   modport slave (
      input  ifid_rs, ifid_rt, idex_mem_read, idex_rt, ex_branch_taken, id_jump,
             mem_req, mem_ready,
      output pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush,
             memwb_flush, mem_timeout, stall_count
   );

endinterface

// File: rtl/pipeline_ctrl_wait_timer.sv
// Purpose: counts memory-stall cycles and flags when the next stall would exhaust the budget.
// Latency: counter updates on the next posedge; term is combinational from the count.
// Backpressure: none; load/inc are accepted every cycle.
module pipeline_ctrl_wait_timer
   import pipeline_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic inc,
   output logic term
);
   localparam int NW = WAIT_W + 1;
   localparam logic [NW-1:0] TERM_VAL = NW'(TIMEOUT_CYC - 1);

   logic [WAIT_W-1:0] wait_cnt;
   logic [NW-1:0]     cnt_plus1;

   // wait_cnt holds the number of stall cycles already spent (load sets 1 for the entry cycle)
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (load) begin
         wait_cnt <= WAIT_W'(1);
      end else if (inc) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

   // Terminal when the current stall cycle brings the total to TIMEOUT_CYC-1
   always_comb begin
      cnt_plus1 = {1'b0, wait_cnt} + NW'(1);
      term      = (cnt_plus1 >= TERM_VAL);
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Purpose: pipeline hold/flush controller: memory stall with timeout, branch, load-use and jump.
// Latency: all hold/flush outputs are combinational (Mealy) in the cycle of the cause.
// Backpressure: memory stall freezes PC..EX/MEM and bubbles MEM/WB until mem_ready or timeout.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic            clk,
   input  logic            reset,
   pipeline_ctrl_if.slave  bus
);

   state_t           state;
   state_t           state_nxt;
   logic             timer_load;
   logic             timer_inc;
   logic             timer_term;
   logic             mem_stall;
   logic             in_timeout;
   logic             load_use;
   ctrl_t            ctrl;
   logic [CNT_W-1:0] stall_count;

   pipeline_ctrl_wait_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wait_timer (
      .clk   (clk),
      .reset (reset),
      .load  (timer_load),
      .inc   (timer_inc),
      .term  (timer_term)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and wait-timer control
   always_comb begin
      state_nxt  = state;
      timer_load = 1'b0;
      timer_inc  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (bus.mem_req && !bus.mem_ready) begin
               state_nxt  = ST_MEM_WAIT;
               timer_load = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (bus.mem_ready) begin
               state_nxt = ST_IDLE;
            end else begin
               timer_inc = 1'b1;
               if (timer_term) begin
                  state_nxt = ST_TIMEOUT;
               end
            end
         end
         ST_TIMEOUT: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Output decode: memory stall/timeout over branch over load-use over jump; all quiet in reset
   always_comb begin
      mem_stall  = !reset && !bus.mem_ready &&
                   (((state == ST_IDLE) && bus.mem_req) || (state == ST_MEM_WAIT));
      in_timeout = !reset && (state == ST_TIMEOUT);
      load_use   = load_use_hit(bus.idex_mem_read, bus.idex_rt, bus.ifid_rs, bus.ifid_rt);
      ctrl       = '0;
      if (mem_stall) begin
         ctrl.pc_hold     = 1'b1;
         ctrl.ifid_hold   = 1'b1;
         ctrl.idex_hold   = 1'b1;
         ctrl.exmem_hold  = 1'b1;
         ctrl.memwb_flush = 1'b1;
      end else if (in_timeout) begin
         ctrl.mem_timeout = 1'b1;
         ctrl.memwb_flush = 1'b1;
      end else if (!reset) begin
         if (bus.ex_branch_taken) begin
            // wrong-path instructions in IF/ID and ID/EX die; no hold so load-use is moot
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
         end else if (load_use) begin
            // jump target is refetched once the stalled ID instruction moves on
            ctrl.pc_hold    = 1'b1;
            ctrl.ifid_hold  = 1'b1;
            ctrl.idex_flush = 1'b1;
         end else if (bus.id_jump) begin
            ctrl.ifid_flush = 1'b1;
         end
      end
   end

   // Saturating count of PC-hold cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
      end else if (ctrl.pc_hold && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

   assign bus.pc_hold     = ctrl.pc_hold;
   assign bus.ifid_hold   = ctrl.ifid_hold;
   assign bus.idex_hold   = ctrl.idex_hold;
   assign bus.exmem_hold  = ctrl.exmem_hold;
   assign bus.ifid_flush  = ctrl.ifid_flush;
   assign bus.idex_flush  = ctrl.idex_flush;
   assign bus.memwb_flush = ctrl.memwb_flush;
   assign bus.mem_timeout = ctrl.mem_timeout;
   assign bus.stall_count = stall_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Purpose: scoreboard bench for pipeline_ctrl: directed hazard scenarios then random traffic.
// Latency: expected control word checked in the same cycle as the stimulus; stall_count one cycle later.
// Backpressure: n/a.
module tb_pipeline_ctrl;
   import pipeline_ctrl_pkg::*;

   localparam int TO   = 16;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   // control word bit positions: {pc,ifid_h,idex_h,exmem_h,ifid_f,idex_f,memwb_f,timeout}
   localparam logic [7:0] B_PC    = 8'h80;
   localparam logic [7:0] B_IFH   = 8'h40;
   localparam logic [7:0] B_IDH   = 8'h20;
   localparam logic [7:0] B_EXH   = 8'h10;
   localparam logic [7:0] B_IFF   = 8'h08;
   localparam logic [7:0] B_IDF   = 8'h04;
   localparam logic [7:0] B_MWB   = 8'h02;
   localparam logic [7:0] B_TO    = 8'h01;
   localparam logic [7:0] W_STALL = B_PC | B_IFH | B_IDH | B_EXH | B_MWB;

   typedef struct packed {
      logic [31:0]   cyc;
      logic [7:0]    ctl;
      logic [CW-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipeline_ctrl_if #(.CNT_W(CW)) bus();

   pipeline_ctrl #(
      .TIMEOUT_CYC (TO),
      .CNT_W       (CW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // reference model: outstanding access, stalls spent on it, pending timeout pulse, hold count
   bit   m_wait = 1'b0;
   bit   m_to   = 1'b0;
   int   m_stalled = 0;
   int   m_cnt  = 0;
   int   cyc    = 0;

   task automatic step(input bit rst, input logic [4:0] rs, input logic [4:0] rt,
                       input bit mr, input logic [4:0] ert, input bit br, input bit jmp,
                       input bit req, input bit rdy);
      logic [7:0] e;
      bit         lu;
      @(posedge clk);
      #1;
      reset               = rst;
      bus.ifid_rs         = rs;
      bus.ifid_rt         = rt;
      bus.idex_mem_read   = mr;
      bus.idex_rt         = ert;
      bus.ex_branch_taken = br;
      bus.id_jump         = jmp;
      bus.mem_req         = req;
      bus.mem_ready       = rdy;
      e = '0;
      if (rst) begin
         m_wait = 1'b0;
         m_to = 1'b0;
         m_stalled = 0;
      end else if (m_to) begin
         e = B_TO | B_MWB;
         m_to = 1'b0;
      end else if ((m_wait || req) && !rdy) begin
         e = W_STALL;
         m_stalled = m_wait ? m_stalled + 1 : 1;
         m_wait = 1'b1;
         if (m_stalled >= TO - 1) begin
            m_to = 1'b1;
            m_wait = 1'b0;
         end
      end else begin
         m_wait = 1'b0;
         m_stalled = 0;
         lu = mr && (ert != 0) && (ert == rs || ert == rt);
         if (br)        e = B_IFF | B_IDF;
         else if (lu)   e = B_PC | B_IFH | B_IDF;
         else if (jmp)  e = B_IFF;
      end
      sb.push_back('{cyc: 32'(cyc), ctl: e, cnt: CW'(m_cnt)});
      if (rst) m_cnt = 0;
      else if (e[7] && m_cnt < CMAX) m_cnt++;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // monitor: outputs are combinational, sampled mid-cycle on the falling edge
   exp_t       mon_e;
   logic [7:0] mon_act;
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         mon_act = {bus.pc_hold, bus.ifid_hold, bus.idex_hold, bus.exmem_hold,
                    bus.ifid_flush, bus.idex_flush, bus.memwb_flush, bus.mem_timeout};
         checks++;
         if (mon_act !== mon_e.ctl) begin
            errors++;
            $display("FAIL ctl cycle %0d: got %b want %b", mon_e.cyc, mon_act, mon_e.ctl);
         end
         checks++;
         if (bus.stall_count !== mon_e.cnt) begin
            errors++;
            $display("FAIL stall_count cycle %0d: got %0d want %0d",
                     mon_e.cyc, bus.stall_count, mon_e.cnt);
         end
      end
   end

   initial begin
      bit stuck;
      bit rdy;
      reset = 1'b1;
      bus.ifid_rs = '0; bus.ifid_rt = '0; bus.idex_mem_read = 1'b0; bus.idex_rt = '0;
      bus.ex_branch_taken = 1'b0; bus.id_jump = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;

      repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      // load-use on rs
      step(0, 8, 3, 1, 8, 0, 0, 0, 0);
      idle(1);
      // load to $zero never hazards
      step(0, 0, 0, 1, 0, 0, 0, 0, 0);
      // three wait cycles then ready
      repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(1);
      // stuck memory: timeout, then a fresh request stalls again
      repeat (17) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(1);
      // ready arrives on the last stall cycle before the budget runs out
      repeat (14) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      // branch together with load-use on rt
      step(0, 5, 6, 1, 6, 1, 0, 0, 0);
      idle(1);
      // branch held during memory wait fires on release
      repeat (2) step(0, 0, 0, 0, 0, 1, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1, 0, 1, 1);
      idle(1);
      // reset during second MEM_WAIT cycle
      repeat (2) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(2);
      // load-use together with jump
      step(0, 7, 0, 1, 7, 0, 1, 0, 0);
      idle(1);

      stuck = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 49) == 0) stuck = ~stuck;
         rdy = stuck ? 1'b0 : ($urandom_range(0, 2) != 0);
         step($urandom_range(0, 99) == 0,
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
              $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 2) != 0, rdy);
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d entries left want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: maximum MEM_WAIT cycles before a forced release (legal range 2..255).
REQ-002 Parameter CNT_W, default 16: width of stall_count.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ifid_rs / ifid_rt  in  5 each  source registers of the instruction in ID.
REQ-006 idex_mem_read  in  1  instruction in EX is a load.
REQ-007 idex_rt  in  5  load destination register in EX.
REQ-008 ex_branch_taken  in  1  branch resolved taken in EX.
REQ-009 id_jump  in  1  jump decoded in ID.
REQ-010 mem_req  in  1  the MEM-stage instruction accesses data memory.
REQ-011 mem_ready  in  1  data memory completes the access this cycle.
REQ-012 pc_hold, ifid_hold, idex_hold, exmem_hold  out  1 each  freeze the PC or the named pipeline register.
REQ-013 ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble (all controls 0) into the named register.
REQ-014 mem_timeout  out  1  one-cycle pulse on forced release.
REQ-015 stall_count  out  CNT_W  count of cycles in which pc_hold=1.

Function
REQ-016 The FSM SHALL have three states: IDLE, MEM_WAIT and TIMEOUT. Outputs SHALL be combinational from the state and the inputs (Mealy).
REQ-017 In IDLE, mem_req=1 with mem_ready=0 SHALL assert the memory stall in the same cycle: pc_hold, ifid_hold, idex_hold, exmem_hold and memwb_flush all 1. Next state SHALL be MEM_WAIT, with wait_cnt loaded to 1.
REQ-018 In IDLE, mem_req=1 with mem_ready=1 SHALL produce no memory stall.
REQ-019 In MEM_WAIT with mem_ready=0:
- the memory stall SHALL stay asserted;
- wait_cnt SHALL increment;
- when wait_cnt = TIMEOUT_CYC-1, next state SHALL be TIMEOUT.
REQ-020 In MEM_WAIT with mem_ready=1, all holds SHALL deassert in that cycle and next state SHALL be IDLE.
REQ-021 TIMEOUT SHALL last exactly one cycle:
- mem_timeout=1;
- no holds;
- exmem_flush behaviour is not provided; memwb_flush=1 discards the failed access;
- next state SHALL be IDLE.
REQ-022 Load-use hazard = idex_mem_read=1 AND idex_rt≠0 AND (idex_rt=ifid_rs OR idex_rt=ifid_rt). It SHALL assert pc_hold, ifid_hold and idex_flush for that cycle.
REQ-023 ex_branch_taken=1 SHALL assert ifid_flush and idex_flush.
REQ-024 id_jump=1 SHALL assert ifid_flush only.
REQ-025 Priority SHALL be, highest first: memory stall/TIMEOUT, then branch flush, then load-use, then jump.
- While a memory stall is asserted, all flush and load-use outputs except memwb_flush SHALL be 0. A branch held in the frozen EX stage takes effect on the release cycle.
- Branch together with load-use SHALL flush only, with no holds.
- Load-use together with jump SHALL suppress ifid_flush.
REQ-026 A hold and a flush SHALL never be simultaneously 1 on the same register.
REQ-027 stall_count SHALL increment on each cycle with pc_hold=1 and saturate at 2^CNT_W-1.

Reset
REQ-028 On reset=1 at posedge clk:
- state SHALL go to IDLE;
- wait_cnt and stall_count SHALL go to 0.
REQ-029 While reset=1, all hold, flush and mem_timeout outputs SHALL be 0, including when reset arrives mid-MEM_WAIT.
REQ-030 The first cycle after reset deasserts SHALL behave as IDLE.

Structure
REQ-031 Package pipeline_ctrl_pkg SHALL hold the state encoding (IDLE=0, MEM_WAIT=1, TIMEOUT=2) and the TIMEOUT_CYC default.
REQ-032 The wait counter SHALL be the sub-module pipeline_ctrl_wait_timer (load, increment, terminal-count flag).
REQ-033 Hazard and priority logic SHALL stay inside pipeline_ctrl.

Verification
REQ-034 Load-use: idex_mem_read=1, idex_rt=8, ifid_rs=8 -> one cycle with pc_hold=ifid_hold=idex_flush=1; stall_count=1.
REQ-035 $zero: idex_mem_read=1, idex_rt=0, ifid_rt=0 -> no hold, no flush.
REQ-036 Memory wait: mem_req=1, mem_ready low for 3 cycles then high -> holds and memwb_flush high for 3 cycles; released on the ready cycle; stall_count=3.
REQ-037 Timeout: mem_req=1, mem_ready stuck 0, TIMEOUT_CYC=16 -> 15 stall cycles, then mem_timeout=1 for 1 cycle, then IDLE.
REQ-038 Simultaneous events:
- ex_branch_taken=1 together with a load-use match -> ifid_flush=idex_flush=1, pc_hold=0.
- ex_branch_taken=1 during MEM_WAIT -> flushes appear only on the release cycle.
REQ-039 Reset in MEM_WAIT cycle 2 -> next cycle all outputs 0, stall_count=0, state IDLE.
